update_packer: RTL and testbench

Downstream neighbour of the serializing update stage in the scatter path. Takes the single 64-bit update stream (one update per cycle), bins each update by destination-vertex partition, packs 8 updates per bin into a 512-bit memory line, and emits completed lines with a write address over a valid/ready handshake to the memory write port. A flush request drains partially filled bins at the end of a scatter phase.

---
 rtl/update_packer_pkg.sv | 20 ++
 rtl/update_packer_if.sv | 33 +++
 rtl/update_packer_line_fifo.sv | 53 +++++
 rtl/update_packer.sv | 194 +++++++++++++++++++
 tb/tb_update_packer.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/update_packer_pkg.sv
// Shared definitions for the update packer: update word layout, line
// geometry, the empty-slot filler and the control FSM state encoding.
package update_packer_pkg;

    localparam int WORD_W     = 64;
    localparam int VAL_W      = 32;
    localparam int DST_LO     = VAL_W;             // destination ID sits above the value
    localparam int LINE_SLOTS = 8;
    localparam int LINE_W     = WORD_W * LINE_SLOTS;
    localparam int COUNT_W    = 4;                 // holds 1..8

    localparam logic [WORD_W-1:0] EMPTY_SLOT = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } pk_state_t;

endpackage

// File: rtl/update_packer_if.sv
// Update-in / line-out bus of the update packer.
//
// Handshake semantics: on the output side a line transfers on every rising
// edge where out_valid && out_ready; while out_valid is high and out_ready
// low, out_line/out_addr/out_count hold steady. The input side has no ready:
// in_valid words are taken every cycle and in_stall is an advisory,
// registered request for upstream to pause.
interface update_packer_if #(
    parameter int ADDR_W = 16
);
    logic [63:0]       in_word;
    logic              in_valid;
    logic              in_stall;
    logic              flush;
    logic              flush_done;
    logic [511:0]      out_line;
    logic [ADDR_W-1:0] out_addr;
    logic [3:0]        out_count;
    logic              out_valid;
    logic              out_ready;

    // Upstream producer plus memory write port side.
    modport master (
        output in_word, in_valid, flush, out_ready,
        input  in_stall, flush_done, out_line, out_addr, out_count, out_valid
    );

    // Packer side.
    modport slave (
        input  in_word, in_valid, flush, out_ready,
        output in_stall, flush_done, out_line, out_addr, out_count, out_valid
    );
endinterface

// File: rtl/update_packer_line_fifo.sv
// Small first-word-fall-through FIFO for completed lines. The head entry is
// presented whenever valid is high; a push into a full FIFO is accepted only
// when a pop happens in the same cycle, otherwise it is ignored (the caller
// flags the loss). Data output reads as zero while empty.
module line_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   occ
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_q;
    logic [PW-1:0] wr_q;
    logic [PW:0]   cnt_q;
    logic          do_push;
    logic          do_pop;

    assign valid   = (cnt_q != '0);
    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign dout    = valid ? mem[rd_q] : '0;
    assign occ     = cnt_q;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_q] <= din;
    end

endmodule

// File: rtl/update_packer.sv
// update_packer: bins 64-bit updates by destination partition, packs eight
// per bin into a 512-bit line and queues finished lines, with their write
// address, for the memory port. A flush drains partially filled bins.
// Optional macro UPDATE_PACKER_STATS_EN builds the saturating update/line
// counters; without it the stat ports read as zero.
module update_packer
    import update_packer_pkg::*;
#(
    parameter int NBINS      = 4,
    parameter int PART_SHIFT = 16,
    parameter int BIN_LINES  = 1024,
    parameter int ADDR_W     = 16
) (
    input  logic           clk,
    input  logic           rst,
    update_packer_if.slave bus,
    output logic           err,
    output logic [31:0]    stat_updates,
    output logic [31:0]    stat_lines,
    output pk_state_t      state_dbg
);
    localparam int BW     = $clog2(NBINS);
    localparam int LW     = $clog2(BIN_LINES);
    localparam int FIFO_W = LINE_W + ADDR_W + COUNT_W;

    // Per-bin line buffers, slot counts and line pointers.
    logic [LINE_SLOTS-1:0][WORD_W-1:0] line_buf [NBINS];
    logic [2:0]                        cnt      [NBINS];
    logic [LW-1:0]                     wptr     [NBINS];

    pk_state_t     state_q, state_d;
    logic [BW-1:0] scan_q, scan_d;
    logic          flush_fire;

    logic [BW-1:0] in_bin;
    logic          accept;
    logic          line_full;
    logic          push;
    logic          pop;
    logic          push_ok;
    logic          drop;
    logic          wrap_evt;

    logic [LINE_W-1:0]  push_line;
    logic [ADDR_W-1:0]  push_addr;
    logic [COUNT_W-1:0] push_count;

    logic [FIFO_W-1:0] fifo_dout;
    logic              fifo_valid;
    logic              fifo_full;
    logic [2:0]        fifo_occ;
    logic [2:0]        occ_next;
    logic              in_stall_q;
    logic              flush_done_q;

    assign in_bin    = bus.in_word[DST_LO+PART_SHIFT +: BW];
    assign accept    = bus.in_valid && (state_q == ST_IDLE);
    assign line_full = accept && (cnt[in_bin] == 3'd7);
    assign push      = line_full || flush_fire;
    assign pop       = fifo_valid && bus.out_ready;
    assign push_ok   = push && (!fifo_full || pop);
    assign drop      = push && fifo_full && !pop;
    assign wrap_evt  = (line_full && (&wptr[in_bin])) || (flush_fire && (&wptr[scan_q]));
    assign occ_next  = fifo_occ + 3'(push_ok) - 3'(pop);

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            scan_q  <= '0;
        end else begin
            state_q <= state_d;
            scan_q  <= scan_d;
        end
    end

    // Flush scan: one bin per cycle, holding while the FIFO has no room.
    always_comb begin
        state_d    = state_q;
        scan_d     = scan_q;
        flush_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.flush) begin
                    state_d = ST_FLUSH;
                    scan_d  = '0;
                end
            end
            ST_FLUSH: begin
                if (!(fifo_full && !pop)) begin
                    flush_fire = (cnt[scan_q] != 3'd0);
                    if (scan_q == BW'(NBINS-1)) state_d = ST_DONE;
                    else                        scan_d  = scan_q + BW'(1);
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Line assembly for either a completed bin or a partial flush.
    always_comb begin
        push_line  = '0;
        push_addr  = '0;
        push_count = '0;
        if (flush_fire) begin
            for (int k = 0; k < LINE_SLOTS; k++) begin
                push_line[k*WORD_W +: WORD_W] = (3'(k) < cnt[scan_q]) ? line_buf[scan_q][k] : EMPTY_SLOT;
            end
            push_addr  = ADDR_W'({scan_q, wptr[scan_q]});
            push_count = {1'b0, cnt[scan_q]};
        end else begin
            push_line                               = line_buf[in_bin];
            push_line[LINE_W-1 -: WORD_W]           = bus.in_word;
            push_addr                               = ADDR_W'({in_bin, wptr[in_bin]});
            push_count                              = COUNT_W'(LINE_SLOTS);
        end
    end

    // Slot counts and line pointers; pointers survive flushes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NBINS; b++) begin
                cnt[b]  <= '0;
                wptr[b] <= '0;
            end
        end else begin
            if (accept) begin
                cnt[in_bin] <= cnt[in_bin] + 3'd1;
                if (line_full) wptr[in_bin] <= wptr[in_bin] + LW'(1);
            end
            if (flush_fire) begin
                cnt[scan_q]  <= '0;
                wptr[scan_q] <= wptr[scan_q] + LW'(1);
            end
        end
    end

    // Slot storage; stale slots are masked by the count.
    always_ff @(posedge clk) begin
        if (accept) line_buf[in_bin][cnt[in_bin]] <= bus.in_word;
    end

    // Registered stall request, flush completion pulse and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_stall_q   <= 1'b0;
            flush_done_q <= 1'b0;
            err          <= 1'b0;
        end else begin
            in_stall_q   <= (occ_next >= 3'd2);
            flush_done_q <= (state_q == ST_DONE);
            if (drop || wrap_evt || (bus.in_valid && state_q != ST_IDLE)) err <= 1'b1;
        end
    end

    line_fifo #(
        .W     (FIFO_W),
        .DEPTH (4)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   ({push_line, push_addr, push_count}),
        .pop   (pop),
        .dout  (fifo_dout),
        .valid (fifo_valid),
        .full  (fifo_full),
        .occ   (fifo_occ)
    );

    assign {bus.out_line, bus.out_addr, bus.out_count} = fifo_dout;
    assign bus.out_valid  = fifo_valid;
    assign bus.in_stall   = in_stall_q;
    assign bus.flush_done = flush_done_q;
    assign state_dbg      = state_q;

`ifdef UPDATE_PACKER_STATS_EN
    // Saturating counters of accepted words and delivered lines.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_updates <= '0;
            stat_lines   <= '0;
        end else begin
            if (accept && (stat_updates != 32'hFFFF_FFFF)) stat_updates <= stat_updates + 32'd1;
            if (pop && (stat_lines != 32'hFFFF_FFFF))      stat_lines   <= stat_lines + 32'd1;
        end
    end
`else
    assign stat_updates = '0;
    assign stat_lines   = '0;
`endif

endmodule

// File: tb/tb_update_packer.sv
// Directed + randomized bench for update_packer. A bin-level reference model
// (arrays of pending words per partition, a line pointer per bin) predicts
// every emitted line into exp_q; a negedge monitor compares handshakes.
module tb_update_packer;
    import update_packer_pkg::*;

    localparam int NBINS      = 4;
    localparam int PART_SHIFT = 16;
    localparam int BIN_LINES  = 1024;
    localparam int ADDR_W     = 16;
    localparam int EXP_W      = LINE_W + ADDR_W + 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        err;
    logic [31:0] stat_updates;
    logic [31:0] stat_lines;
    pk_state_t   state_dbg;

    update_packer_if #(.ADDR_W(ADDR_W)) bus();

    update_packer #(
        .NBINS(NBINS), .PART_SHIFT(PART_SHIFT), .BIN_LINES(BIN_LINES), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .err(err),
        .stat_updates(stat_updates), .stat_lines(stat_lines), .state_dbg(state_dbg)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        #3_000_000;
        n_fail++;
        $display("FAIL watchdog: observed timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // Reference model state.
    logic [EXP_W-1:0] exp_q[$];
    logic [63:0]      bin_words [NBINS][LINE_SLOTS];
    int               bin_n     [NBINS];
    int               line_ptr  [NBINS];
    int               n_words;
    int               n_lines_model;
    int               n_hs;
    bit               rnd_ready;

    task automatic check(input string tag, input logic [EXP_W-1:0] got, input logic [EXP_W-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        for (int b = 0; b < NBINS; b++) begin
            bin_n[b]    = 0;
            line_ptr[b] = 0;
        end
        n_words       = 0;
        n_lines_model = 0;
        n_hs          = 0;
    endfunction

    function automatic void model_emit(input int b);
        logic [LINE_W-1:0] line;
        for (int k = 0; k < LINE_SLOTS; k++)
            line[k*64 +: 64] = (k < bin_n[b]) ? bin_words[b][k] : EMPTY_SLOT;
        exp_q.push_back({line, ADDR_W'(b * BIN_LINES + line_ptr[b]), 4'(bin_n[b])});
        line_ptr[b] = (line_ptr[b] + 1) % BIN_LINES;
        bin_n[b]    = 0;
        n_lines_model++;
    endfunction

    function automatic void model_accept(input logic [63:0] w);
        int b;
        b = int'((w[63:32] >> PART_SHIFT) % NBINS);
        bin_words[b][bin_n[b]] = w;
        bin_n[b]++;
        n_words++;
        if (bin_n[b] == LINE_SLOTS) model_emit(b);
    endfunction

    function automatic void model_flush();
        for (int b = 0; b < NBINS; b++)
            if (bin_n[b] > 0) model_emit(b);
    endfunction

    function automatic logic [63:0] mk_word(input int b);
        logic [31:0] dst;
        dst = $urandom();
        dst[PART_SHIFT +: 2] = 2'(b);
        return {dst, 32'($urandom())};
    endfunction

    // Scoreboard: every handshake must match the head of exp_q.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            check("line_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
                check("line", {bus.out_line, bus.out_addr, bus.out_count}, exp_q.pop_front());
            n_hs++;
        end
    end

    // Driver tasks; the main sequence always resumes 1 time unit after posedge.
    task automatic tick();
        @(posedge clk); #1;
        if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drive_word(input logic [63:0] w, input bit to_model);
        bus.in_word  = w;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        if (to_model) model_accept(w);
    endtask

    task automatic pulse_flush(input bit to_model);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        if (to_model) model_flush();
    endtask

    task automatic wait_flush_done(output int lat);
        bit found;
        found = 0;
        lat   = 0;
        for (int c = 1; c <= 200 && !found; c++) begin
            @(negedge clk);
            if (bus.flush_done) begin found = 1; lat = c; end
            else tick();
        end
        if (found) tick();
    endtask

    task automatic wait_drain(input string tag);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && c < 2000) begin tick(); c++; end
        check(tag, (exp_q.size() == 0 && !bus.out_valid), 1);
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    initial begin
        logic [63:0] first_w;
        int          lat;
        int          c;

        bus.in_word = '0; bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        rnd_ready = 0;
        do_reset();

        // Reset values.
        at_neg();
        check("rst_state", state_dbg, ST_IDLE);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_stall", bus.in_stall, 0);
        check("rst_flush_done", bus.flush_done, 0);
        check("rst_err", err, 0);
        check("rst_outputs", {bus.out_line, bus.out_addr, bus.out_count}, 0);
        check("rst_stats", {stat_updates, stat_lines}, 0);
        tick();

        // One full line to bin 0, latency one cycle after the 8th word.
        bus.out_ready = 1'b1;
        first_w = {32'h0000_0005, 32'($urandom())};
        drive_word(first_w, 1);
        for (int i = 1; i < 7; i++) drive_word({32'h0000_0005, 32'($urandom())}, 1);
        at_neg();
        check("no_line_before_8th", bus.out_valid, 0);
        tick();
        drive_word({32'h0000_0005, 32'($urandom())}, 1);
        at_neg();
        check("line_latency_valid", bus.out_valid, 1);
        check("line_addr_bin0", bus.out_addr, 0);
        check("line_count_full", bus.out_count, 8);
        check("line_slot0", bus.out_line[63:0], first_w);
        tick();
        wait_drain("drain_bin0");

        // Interleaved bins 2 and 3.
        for (int i = 0; i < 16; i++) drive_word(mk_word((i % 2 == 0) ? 2 : 3), 1);
        wait_drain("drain_bins23");

        // Backpressure: 40 words to bin 1 with the port stalled.
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            drive_word(mk_word(1), 1);
            if (i == 8) begin at_neg(); check("stall_occ1", bus.in_stall, 0); tick(); end
            if (i == 16) begin at_neg(); check("stall_occ2", bus.in_stall, 1); tick(); end
            if (i == 32) begin
                at_neg();
                check("err_fifo_full_ok", err, 0);
                check("hold_head", {bus.out_valid, bus.out_addr, bus.out_count}, {1'b1, 16'd1024, 4'd8});
                tick();
            end
        end
        void'(exp_q.pop_back());
        at_neg();
        check("err_overflow", err, 1);
        tick();

        // Reset with lines queued discards them.
        do_reset();
        at_neg();
        check("rst_discard_valid", bus.out_valid, 0);
        check("rst_discard_err", err, 0);
        check("rst_discard_stall", bus.in_stall, 0);
        tick();

        // Partial flush: 3 words to bin 0, 5 to bin 3.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) drive_word(mk_word(0), 1);
        for (int i = 0; i < 5; i++) drive_word(mk_word(3), 1);
        pulse_flush(1);
        wait_flush_done(lat);
        check("flush_done_seen", lat != 0, 1);
        at_neg();
        check("flush_done_pulse", bus.flush_done, 0);
        tick();
        wait_drain("drain_flush");

        // Flush with every bin empty.
        pulse_flush(1);
        wait_flush_done(lat);
        check("flush_empty_latency", lat, NBINS + 2);
        check("err_before_drop", err, 0);

        // Word during FLUSH is dropped and flagged.
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        drive_word(mk_word(2), 0);
        wait_flush_done(lat);
        check("flush_done_after_drop", lat != 0, 1);
        at_neg();
        check("err_in_valid_flush", err, 1);
        tick();
        wait_drain("drain_after_drop");

        // Line pointer wrap on bin 1.
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < BIN_LINES * 8 - 1; i++) drive_word(mk_word(1), 1);
        at_neg();
        check("err_before_wrap", err, 0);
        tick();
        drive_word(mk_word(1), 1);
        at_neg();
        check("err_wrap", err, 1);
        tick();
        wait_drain("drain_wrap");
        do_reset();
        at_neg();
        check("rst_clears_err", err, 0);
        tick();
        for (int i = 0; i < 8; i++) drive_word(mk_word(1), 1);
        wait_drain("wptr_cleared");

        // Randomized traffic with random backpressure, honouring in_stall.
        do_reset();
        rnd_ready = 1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 4) == 0) tick();
            else begin
                c = 0;
                while (bus.in_stall && c < 100) begin tick(); c++; end
                if (c >= 100) check("stall_timeout", c, 0);
                drive_word(mk_word(int'($urandom_range(0, NBINS - 1))), 1);
            end
        end
        pulse_flush(1);
        wait_flush_done(lat);
        check("rand_flush_done", lat != 0, 1);
        rnd_ready = 0;
        bus.out_ready = 1'b1;
        wait_drain("drain_random");
        check("rand_err", err, 0);
        check("rand_line_total", n_hs, n_lines_model);
`ifdef UPDATE_PACKER_STATS_EN
        check("stat_updates", stat_updates, n_words);
        check("stat_lines", stat_lines, n_hs);
`else
        check("stat_updates_off", stat_updates, 0);
        check("stat_lines_off", stat_lines, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
